reg_op_sequencer: RTL and testbench
===================================

# reg_op_sequencer

Command sequencer that sits directly upstream of the 4-entry, 8-bit register file. It turns one-shot register commands (load immediate, move, add, read) into the file's single-port enable/read-write/select cycle sequence and returns one result per command. The register file has registered reads, so the sequencer inserts a capture cycle after every read. It is the only master of the register-file port.

## Interface
Parameters:
- none; data width fixed at 8, register select fixed at 2 bits.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-high; one clock, reset sampled on posedge clk.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  sequencer idle; command accepted on the edge where cmd_valid & cmd_ready.
- cmd_op  in  2  00 LDI, 01 MOV, 10 ADD, 11 RDR.
- cmd_rd  in  2  destination/target register.
- cmd_rs  in  2  source register (MOV, ADD).
- cmd_imm  in  8  immediate (LDI).
- rf_select  out  2  to register file register_select.
- rf_enable  out  1  to register file mem_enable.
- rf_read_write  out  1  to register file read_write; 1 = read, 0 = write.
- rf_wdata  out  8  to register file data_bus_in.
- rf_rdata  in  8  from register file data_bus_out; valid after the edge that performed a read, only while rf_read_write = 1.
- rsp_valid  out  1  one-cycle result pulse; no backpressure.
- rsp_data  out  8  result value.
- rsp_carry  out  1  carry out of ADD; 0 for other ops.

## Operation
- All outputs registered except cmd_ready = (state == IDLE) & ~reset.
- Fields latched into internal op/rd/rs/imm on acceptance; inputs ignored afterward.
- rf_read_write held at 1 in every state except WR, so rf_rdata stays valid for capture.
- States: IDLE, RD_A, CAP_A, RD_B, CAP_B, WR, RESP.
- IDLE: rf_enable 0. On accept: LDI -> WR; MOV, ADD -> RD_A with select rs; RDR -> RD_A with select rd.
- RD_A: rf_enable 1, rf_read_write 1 -> CAP_A.
- CAP_A: rf_enable 0; op_a <= rf_rdata. ADD -> RD_B with select rd; MOV -> WR; RDR -> RESP.
- RD_B: rf_enable 1, read rd -> CAP_B.
- CAP_B: op_b <= rf_rdata. Sum = {1'b0, op_a} + {1'b0, op_b} (9 bits) -> WR.
- WR: rf_enable 1, rf_read_write 0, rf_select rd, rf_wdata = imm (LDI) / op_a (MOV) / sum[7:0] (ADD) -> RESP.
- RESP: rsp_valid 1, rsp_data = written value (or op_a for RDR), rsp_carry = sum[8] for ADD, else 0 -> IDLE.
- rsp_data and rsp_carry hold their values until the next RESP.
- Arithmetic: 8-bit wrap; 0xFF + 0x01 = 0x00, carry 1.
- ADD with rd == rs reads the same register twice; result is 2×value.

## Timing
- Acceptance edge = E0. The state after E0 is the first state listed.
- Cycles from E0 to rsp_valid: LDI 2 (WR, RESP), RDR 3, MOV 4, ADD 6.
- cmd_ready rises in the cycle after RESP. Back-to-back throughput is one command per latency + 1 cycles.
- Register-file write lands on the edge ending WR. A command issued after RESP sees the new value.
- cmd_valid held with cmd_ready low is not an error; the command is accepted when the sequencer returns to IDLE.
- Reset values: state IDLE, rf_enable 0, rf_read_write 1, rf_select 0, rf_wdata 0, rsp_valid 0, rsp_data 0, rsp_carry 0, internal latches 0.
- Reset mid-command: the sequence is abandoned and no response is produced. No rf_enable is asserted from the reset edge onward. A write already completed at an earlier edge remains in the register file.
- reset and cmd_valid in the same cycle: the command is not accepted.

## Test plan
- Reset, then LDI r2 = 0x5A -> WR cycle shows select 2, enable 1, rw 0, wdata 0x5A; rsp_valid exactly 2 cycles after accept with rsp_data 0x5A and carry 0.
- LDI r0 = 0x11, then MOV r3 <- r0, then RDR r3 -> MOV response 0x11 at accept+4; RDR response 0x11 at accept+3; rw never 0 during the RDR.
- LDI r1 = 0xFF, LDI r2 = 0x01, ADD r2 += r1 -> rsp_data 0x00, rsp_carry 1 at accept+6; RDR r2 returns 0x00.
- ADD r1 += r1 with r1 = 0x40 -> two reads of select 1, then write 0x80 with carry 0.
- Hold cmd_valid high continuously with 4 queued commands -> each command accepted only in IDLE; exactly 4 rsp_valid pulses; no accept while busy.
- Assert reset during CAP_B of an ADD -> no WR cycle, no rsp_valid; outputs at reset values the next cycle; the target register is unchanged on a later RDR.

Source files
------------

// File: rtl/reg_op_sequencer_if.sv
// Bundle of command, register-file and response signals between the
// sequencer (master) and its environment (slave).
interface reg_op_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [1:0] cmd_rd;
  logic [1:0] cmd_rs;
  logic [7:0] cmd_imm;
  logic [1:0] rf_select;
  logic       rf_enable;
  logic       rf_read_write;
  logic [7:0] rf_wdata;
  logic [7:0] rf_rdata;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_carry;

  modport master (
    input  cmd_valid, cmd_op, cmd_rd, cmd_rs, cmd_imm, rf_rdata,
    output cmd_ready, rf_select, rf_enable, rf_read_write, rf_wdata,
           rsp_valid, rsp_data, rsp_carry
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_rd, cmd_rs, cmd_imm, rf_rdata,
    input  cmd_ready, rf_select, rf_enable, rf_read_write, rf_wdata,
           rsp_valid, rsp_data, rsp_carry
  );
endinterface

// File: rtl/reg_op_sequencer.sv
// Turns LDI/MOV/ADD/RDR commands into single-port register-file cycles
// with a capture cycle after each registered read; one response per command.
module reg_op_sequencer (
  input  logic               clk,
  input  logic               reset,
  reg_op_sequencer_if.master bus
);
  typedef enum logic [2:0] {IDLE, RD_A, CAP_A, RD_B, CAP_B, WR, RESP} state_t;

  localparam logic [1:0] OP_LDI = 2'b00;
  localparam logic [1:0] OP_MOV = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;
  localparam logic [1:0] OP_RDR = 2'b11;

  state_t      state_q, state_d;
  logic [1:0]  op_q, op_d, rd_q, rd_d, rs_q, rs_d;
  logic [7:0]  imm_q, imm_d, op_a_q, op_a_d;
  logic [8:0]  sum_q, sum_d;
  logic [1:0]  rf_select_q, rf_select_d;
  logic        rf_enable_q, rf_enable_d;
  logic        rf_read_write_q, rf_read_write_d;
  logic [7:0]  rf_wdata_q, rf_wdata_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [7:0]  rsp_data_q, rsp_data_d;
  logic        rsp_carry_q, rsp_carry_d;
  logic        accept;

  assign bus.cmd_ready = (state_q == IDLE) & ~reset;
  assign accept        = bus.cmd_valid & bus.cmd_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      op_q            <= 2'd0;
      rd_q            <= 2'd0;
      rs_q            <= 2'd0;
      imm_q           <= 8'd0;
      op_a_q          <= 8'd0;
      sum_q           <= 9'd0;
      rf_select_q     <= 2'd0;
      rf_enable_q     <= 1'b0;
      rf_read_write_q <= 1'b1;
      rf_wdata_q      <= 8'd0;
      rsp_valid_q     <= 1'b0;
      rsp_data_q      <= 8'd0;
      rsp_carry_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      op_q            <= op_d;
      rd_q            <= rd_d;
      rs_q            <= rs_d;
      imm_q           <= imm_d;
      op_a_q          <= op_a_d;
      sum_q           <= sum_d;
      rf_select_q     <= rf_select_d;
      rf_enable_q     <= rf_enable_d;
      rf_read_write_q <= rf_read_write_d;
      rf_wdata_q      <= rf_wdata_d;
      rsp_valid_q     <= rsp_valid_d;
      rsp_data_q      <= rsp_data_d;
      rsp_carry_q     <= rsp_carry_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = (bus.cmd_op == OP_LDI) ? WR : RD_A;
      RD_A:    state_d = CAP_A;
      CAP_A: begin
        if (op_q == OP_ADD)      state_d = RD_B;
        else if (op_q == OP_MOV) state_d = WR;
        else                     state_d = RESP;
      end
      RD_B:    state_d = CAP_B;
      CAP_B:   state_d = WR;
      WR:      state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered, so they are computed for the state being entered;
  // write data comes straight from rf_rdata in the capture cycle that precedes WR.
  always_comb begin
    op_d            = op_q;
    rd_d            = rd_q;
    rs_d            = rs_q;
    imm_d           = imm_q;
    op_a_d          = op_a_q;
    sum_d           = sum_q;
    rf_select_d     = rf_select_q;
    rf_wdata_d      = rf_wdata_q;
    rsp_data_d      = rsp_data_q;
    rsp_carry_d     = rsp_carry_q;
    rf_enable_d     = (state_d == RD_A) || (state_d == RD_B) || (state_d == WR);
    rf_read_write_d = (state_d != WR);
    rsp_valid_d     = (state_d == RESP);
    case (state_q)
      IDLE: begin
        if (accept) begin
          op_d  = bus.cmd_op;
          rd_d  = bus.cmd_rd;
          rs_d  = bus.cmd_rs;
          imm_d = bus.cmd_imm;
          if (bus.cmd_op == OP_LDI) begin
            rf_select_d = bus.cmd_rd;
            rf_wdata_d  = bus.cmd_imm;
          end else if (bus.cmd_op == OP_RDR) begin
            rf_select_d = bus.cmd_rd;
          end else begin
            rf_select_d = bus.cmd_rs;
          end
        end
      end
      CAP_A: begin
        op_a_d = bus.rf_rdata;
        if (op_q == OP_ADD) begin
          rf_select_d = rd_q;
        end else if (op_q == OP_MOV) begin
          rf_select_d = rd_q;
          rf_wdata_d  = bus.rf_rdata;
        end else begin
          rsp_data_d  = bus.rf_rdata;
          rsp_carry_d = 1'b0;
        end
      end
      CAP_B: begin
        sum_d       = {1'b0, op_a_q} + {1'b0, bus.rf_rdata};
        rf_select_d = rd_q;
        rf_wdata_d  = sum_d[7:0];
      end
      WR: begin
        rsp_data_d  = rf_wdata_q;
        rsp_carry_d = (op_q == OP_ADD) & sum_q[8];
      end
      default: ;
    endcase
  end

  assign bus.rf_select     = rf_select_q;
  assign bus.rf_enable     = rf_enable_q;
  assign bus.rf_read_write = rf_read_write_q;
  assign bus.rf_wdata      = rf_wdata_q;
  assign bus.rsp_valid     = rsp_valid_q;
  assign bus.rsp_data      = rsp_data_q;
  assign bus.rsp_carry     = rsp_carry_q;
endmodule

// File: tb/tb_reg_op_sequencer.sv
// Directed bench: sequencer driving a behavioural 4x8 register file with
// registered reads; each scenario task checks its own results.
module tb_reg_op_sequencer;
  localparam logic [1:0] LDI = 2'b00;
  localparam logic [1:0] MOV = 2'b01;
  localparam logic [1:0] ADD = 2'b10;
  localparam logic [1:0] RDR = 2'b11;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   passes = 0;

  always #5 clk = ~clk;

  reg_op_sequencer_if bus ();
  reg_op_sequencer dut (.clk(clk), .reset(reset), .bus(bus));

  logic [7:0] rf_mem [4];
  logic [7:0] rf_dout = 8'h00;
  always @(posedge clk) begin
    if (bus.rf_enable) begin
      if (bus.rf_read_write) rf_dout <= rf_mem[bus.rf_select];
      else                   rf_mem[bus.rf_select] <= bus.rf_wdata;
    end
  end
  assign bus.rf_rdata = rf_dout;

  // Offers one command, waits for acceptance and the response, and reports
  // what was seen on the register-file port in between.
  task automatic issue(input logic [1:0] op, input logic [1:0] rd, input logic [1:0] rs,
                       input logic [7:0] imm, output int lat, output logic [7:0] data,
                       output logic carry, output int nrd, output logic [1:0] rsel0,
                       output logic [1:0] rsel1, output int nwr, output logic [1:0] wsel,
                       output logic [7:0] wdat, output int nrw0);
    int waitn;
    bus.cmd_op = op; bus.cmd_rd = rd; bus.cmd_rs = rs; bus.cmd_imm = imm;
    bus.cmd_valid = 1'b1;
    nrd = 0; nwr = 0; nrw0 = 0; rsel0 = 2'd0; rsel1 = 2'd0; wsel = 2'd0; wdat = 8'h00;
    data = 8'h00; carry = 1'b0; waitn = 0;
    while (!bus.cmd_ready && waitn < 40) begin
      @(posedge clk); #1; waitn++;
    end
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    lat = 1;
    while (!bus.rsp_valid && lat < 20) begin
      if (!bus.rf_read_write) nrw0++;
      if (bus.rf_enable && bus.rf_read_write) begin
        if (nrd == 0) rsel0 = bus.rf_select; else rsel1 = bus.rf_select;
        nrd++;
      end
      if (bus.rf_enable && !bus.rf_read_write) begin
        wsel = bus.rf_select; wdat = bus.rf_wdata; nwr++;
      end
      @(posedge clk); #1; lat++;
    end
    if (bus.rsp_valid) begin
      data = bus.rsp_data; carry = bus.rsp_carry;
    end else begin
      lat = 99;
    end
    $display("cmd op=%0d rd=%0d rs=%0d imm=%02h -> lat=%0d data=%02h carry=%0d reads=%0d writes=%0d",
             op, rd, rs, imm, lat, data, carry, nrd, nwr);
  endtask

  task automatic test_reset();
    int en_cnt;
    reset = 1'b1;
    bus.cmd_op = LDI; bus.cmd_rd = 2'd0; bus.cmd_rs = 2'd0; bus.cmd_imm = 8'hAA;
    bus.cmd_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.rf_enable !== 1'b0) $display("FAIL reset_enable: got %0d want 0", bus.rf_enable); else passes++;
    checks++; if (bus.rf_read_write !== 1'b1) $display("FAIL reset_rw: got %0d want 1", bus.rf_read_write); else passes++;
    checks++; if (bus.rf_select !== 2'd0) $display("FAIL reset_select: got %0d want 0", bus.rf_select); else passes++;
    checks++; if (bus.rf_wdata !== 8'h00) $display("FAIL reset_wdata: got %02h want 00", bus.rf_wdata); else passes++;
    checks++; if (bus.rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %0d want 0", bus.rsp_valid); else passes++;
    checks++; if (bus.rsp_data !== 8'h00) $display("FAIL reset_rsp_data: got %02h want 00", bus.rsp_data); else passes++;
    checks++; if (bus.rsp_carry !== 1'b0) $display("FAIL reset_rsp_carry: got %0d want 0", bus.rsp_carry); else passes++;
    checks++; if (bus.cmd_ready !== 1'b0) $display("FAIL reset_cmd_ready: got %0d want 0", bus.cmd_ready); else passes++;
    reset = 1'b0;
    bus.cmd_valid = 1'b0;
    en_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (bus.rf_enable || bus.rsp_valid) en_cnt++;
    end
    checks++; if (en_cnt !== 0) $display("FAIL reset_cmd_ignored: activity cycles %0d want 0", en_cnt); else passes++;
    checks++; if (bus.cmd_ready !== 1'b1) $display("FAIL idle_cmd_ready: got %0d want 1", bus.cmd_ready); else passes++;
    $display("reset sequence done");
  endtask

  task automatic test_ldi();
    int lat, nrd, nwr, nrw0;
    logic [7:0] data, wdat;
    logic carry;
    logic [1:0] rsel0, rsel1, wsel;
    issue(LDI, 2'd2, 2'd0, 8'h5A, lat, data, carry, nrd, rsel0, rsel1, nwr, wsel, wdat, nrw0);
    checks++; if (lat !== 2) $display("FAIL ldi_latency: got %0d want 2", lat); else passes++;
    checks++; if (data !== 8'h5A) $display("FAIL ldi_data: got %02h want 5a", data); else passes++;
    checks++; if (carry !== 1'b0) $display("FAIL ldi_carry: got %0d want 0", carry); else passes++;
    checks++; if (nwr !== 1 || wsel !== 2'd2 || wdat !== 8'h5A)
      $display("FAIL ldi_write: got n=%0d sel=%0d data=%02h want n=1 sel=2 data=5a", nwr, wsel, wdat); else passes++;
    checks++; if (nrd !== 0) $display("FAIL ldi_reads: got %0d want 0", nrd); else passes++;
    checks++; if (bus.cmd_ready !== 1'b0) $display("FAIL ldi_ready_in_resp: got %0d want 0", bus.cmd_ready); else passes++;
    @(posedge clk); #1;
    checks++; if (bus.rsp_valid !== 1'b0) $display("FAIL ldi_pulse_width: rsp_valid %0d want 0", bus.rsp_valid); else passes++;
    checks++; if (bus.cmd_ready !== 1'b1) $display("FAIL ldi_ready_after: got %0d want 1", bus.cmd_ready); else passes++;
    checks++; if (bus.rsp_data !== 8'h5A) $display("FAIL ldi_data_hold: got %02h want 5a", bus.rsp_data); else passes++;
  endtask

  task automatic test_mov_rdr();
    int lat, nrd, nwr, nrw0;
    logic [7:0] data, wdat;
    logic carry;
    logic [1:0] rsel0, rsel1, wsel;
    issue(LDI, 2'd0, 2'd0, 8'h11, lat, data, carry, nrd, rsel0, rsel1, nwr, wsel, wdat, nrw0);
    issue(MOV, 2'd3, 2'd0, 8'h00, lat, data, carry, nrd, rsel0, rsel1, nwr, wsel, wdat, nrw0);
    checks++; if (lat !== 4) $display("FAIL mov_latency: got %0d want 4", lat); else passes++;
    checks++; if (data !== 8'h11) $display("FAIL mov_data: got %02h want 11", data); else passes++;
    checks++; if (nrd !== 1 || rsel0 !== 2'd0) $display("FAIL mov_read: got n=%0d sel=%0d want n=1 sel=0", nrd, rsel0); else passes++;
    checks++; if (nwr !== 1 || wsel !== 2'd3 || wdat !== 8'h11)
      $display("FAIL mov_write: got n=%0d sel=%0d data=%02h want n=1 sel=3 data=11", nwr, wsel, wdat); else passes++;
    issue(RDR, 2'd3, 2'd1, 8'h00, lat, data, carry, nrd, rsel0, rsel1, nwr, wsel, wdat, nrw0);
    checks++; if (lat !== 3) $display("FAIL rdr_latency: got %0d want 3", lat); else passes++;
    checks++; if (data !== 8'h11) $display("FAIL rdr_data: got %02h want 11", data); else passes++;
    checks++; if (nrw0 !== 0) $display("FAIL rdr_no_write_cycle: rw=0 cycles %0d want 0", nrw0); else passes++;
    checks++; if (nrd !== 1 || rsel0 !== 2'd3) $display("FAIL rdr_read: got n=%0d sel=%0d want n=1 sel=3", nrd, rsel0); else passes++;
    @(posedge clk); #1;
  endtask

  task automatic test_add_carry();
    int lat, nrd, nwr, nrw0;
    logic [7:0] data, wdat;
    logic carry;
    logic [1:0] rsel0, rsel1, wsel;
    issue(LDI, 2'd1, 2'd0, 8'hFF, lat, data, carry, nrd, rsel0, rsel1, nwr, wsel, wdat, nrw0);
    issue(LDI, 2'd2, 2'd0, 8'h01, lat, data, carry, nrd, rsel0, rsel1, nwr, wsel, wdat, nrw0);
    issue(ADD, 2'd2, 2'd1, 8'h00, lat, data, carry, nrd, rsel0, rsel1, nwr, wsel, wdat, nrw0);
    checks++; if (lat !== 6) $display("FAIL add_latency: got %0d want 6", lat); else passes++;
    checks++; if (data !== 8'h00) $display("FAIL add_wrap_data: got %02h want 00", data); else passes++;
    checks++; if (carry !== 1'b1) $display("FAIL add_carry: got %0d want 1", carry); else passes++;
    checks++; if (nrd !== 2 || rsel0 !== 2'd1 || rsel1 !== 2'd2)
      $display("FAIL add_read_order: got n=%0d sel=%0d,%0d want n=2 sel=1,2", nrd, rsel0, rsel1); else passes++;
    checks++; if (nwr !== 1 || wsel !== 2'd2 || wdat !== 8'h00)
      $display("FAIL add_write: got n=%0d sel=%0d data=%02h want n=1 sel=2 data=00", nwr, wsel, wdat); else passes++;
    issue(RDR, 2'd2, 2'd0, 8'h00, lat, data, carry, nrd, rsel0, rsel1, nwr, wsel, wdat, nrw0);
    checks++; if (data !== 8'h00) $display("FAIL add_readback: got %02h want 00", data); else passes++;
    checks++; if (carry !== 1'b0) $display("FAIL rdr_carry_clear: got %0d want 0", carry); else passes++;
    @(posedge clk); #1;
  endtask

  task automatic test_add_self();
    int lat, nrd, nwr, nrw0;
    logic [7:0] data, wdat;
    logic carry;
    logic [1:0] rsel0, rsel1, wsel;
    issue(LDI, 2'd1, 2'd0, 8'h40, lat, data, carry, nrd, rsel0, rsel1, nwr, wsel, wdat, nrw0);
    issue(ADD, 2'd1, 2'd1, 8'h00, lat, data, carry, nrd, rsel0, rsel1, nwr, wsel, wdat, nrw0);
    checks++; if (nrd !== 2 || rsel0 !== 2'd1 || rsel1 !== 2'd1)
      $display("FAIL self_add_reads: got n=%0d sel=%0d,%0d want n=2 sel=1,1", nrd, rsel0, rsel1); else passes++;
    checks++; if (nwr !== 1 || wsel !== 2'd1 || wdat !== 8'h80)
      $display("FAIL self_add_write: got n=%0d sel=%0d data=%02h want n=1 sel=1 data=80", nwr, wsel, wdat); else passes++;
    checks++; if (data !== 8'h80 || carry !== 1'b0)
      $display("FAIL self_add_rsp: got data=%02h carry=%0d want 80/0", data, carry); else passes++;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [1:0] q_op [4];
    logic [1:0] q_rd [4];
    logic [1:0] q_rs [4];
    logic [7:0] q_imm [4];
    logic [7:0] exp_rsp [4];
    logic [7:0] got_rsp [4];
    int acc_cyc [4];
    int nacc, nrsp;
    logic rdy;
    q_op[0] = LDI; q_rd[0] = 2'd0; q_rs[0] = 2'd0; q_imm[0] = 8'h03; exp_rsp[0] = 8'h03;
    q_op[1] = LDI; q_rd[1] = 2'd1; q_rs[1] = 2'd0; q_imm[1] = 8'h04; exp_rsp[1] = 8'h04;
    q_op[2] = ADD; q_rd[2] = 2'd0; q_rs[2] = 2'd1; q_imm[2] = 8'h00; exp_rsp[2] = 8'h07;
    q_op[3] = RDR; q_rd[3] = 2'd0; q_rs[3] = 2'd0; q_imm[3] = 8'h00; exp_rsp[3] = 8'h07;
    for (int i = 0; i < 4; i++) begin
      acc_cyc[i] = 0; got_rsp[i] = 8'h00;
    end
    nacc = 0; nrsp = 0;
    bus.cmd_op = q_op[0]; bus.cmd_rd = q_rd[0]; bus.cmd_rs = q_rs[0]; bus.cmd_imm = q_imm[0];
    bus.cmd_valid = 1'b1;
    for (int c = 0; c < 60; c++) begin
      rdy = bus.cmd_ready;
      @(posedge clk); #1;
      if (rdy && bus.cmd_valid) begin
        acc_cyc[nacc] = c;
        $display("b2b accept #%0d at cycle %0d op=%0d", nacc, c, q_op[nacc]);
        nacc++;
        if (nacc < 4) begin
          bus.cmd_op = q_op[nacc]; bus.cmd_rd = q_rd[nacc];
          bus.cmd_rs = q_rs[nacc]; bus.cmd_imm = q_imm[nacc];
        end else begin
          bus.cmd_valid = 1'b0;
        end
      end
      if (bus.rsp_valid) begin
        if (nrsp < 4) got_rsp[nrsp] = bus.rsp_data;
        $display("b2b response #%0d at cycle %0d data=%02h carry=%0d", nrsp, c, bus.rsp_data, bus.rsp_carry);
        nrsp++;
      end
    end
    bus.cmd_valid = 1'b0;
    checks++; if (nacc !== 4) $display("FAIL b2b_accepts: got %0d want 4", nacc); else passes++;
    checks++; if (nrsp !== 4) $display("FAIL b2b_responses: got %0d want 4", nrsp); else passes++;
    checks++; if (acc_cyc[1] - acc_cyc[0] !== 3) $display("FAIL b2b_spacing_0: got %0d want 3", acc_cyc[1] - acc_cyc[0]); else passes++;
    checks++; if (acc_cyc[2] - acc_cyc[1] !== 3) $display("FAIL b2b_spacing_1: got %0d want 3", acc_cyc[2] - acc_cyc[1]); else passes++;
    checks++; if (acc_cyc[3] - acc_cyc[2] !== 7) $display("FAIL b2b_spacing_2: got %0d want 7", acc_cyc[3] - acc_cyc[2]); else passes++;
    for (int i = 0; i < 4; i++) begin
      checks++; if (got_rsp[i] !== exp_rsp[i]) $display("FAIL b2b_rsp_%0d: got %02h want %02h", i, got_rsp[i], exp_rsp[i]); else passes++;
    end
  endtask

  task automatic test_reset_mid_add();
    int lat, nrd, nwr, nrw0, waitn, act;
    logic [7:0] data, wdat;
    logic carry;
    logic [1:0] rsel0, rsel1, wsel;
    issue(LDI, 2'd3, 2'd0, 8'h22, lat, data, carry, nrd, rsel0, rsel1, nwr, wsel, wdat, nrw0);
    issue(LDI, 2'd1, 2'd0, 8'h05, lat, data, carry, nrd, rsel0, rsel1, nwr, wsel, wdat, nrw0);
    bus.cmd_op = ADD; bus.cmd_rd = 2'd3; bus.cmd_rs = 2'd1; bus.cmd_imm = 8'h00;
    bus.cmd_valid = 1'b1;
    waitn = 0;
    while (!bus.cmd_ready && waitn < 40) begin
      @(posedge clk); #1; waitn++;
    end
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    // Now in CAP_B: the reset edge must cancel the pending write to r3.
    reset = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.rf_enable !== 1'b0) $display("FAIL mid_reset_enable: got %0d want 0", bus.rf_enable); else passes++;
    checks++; if (bus.rf_read_write !== 1'b1) $display("FAIL mid_reset_rw: got %0d want 1", bus.rf_read_write); else passes++;
    checks++; if (bus.rf_select !== 2'd0 || bus.rf_wdata !== 8'h00)
      $display("FAIL mid_reset_bus: got sel=%0d wdata=%02h want 0/00", bus.rf_select, bus.rf_wdata); else passes++;
    checks++; if (bus.rsp_valid !== 1'b0 || bus.rsp_data !== 8'h00 || bus.rsp_carry !== 1'b0)
      $display("FAIL mid_reset_rsp: got v=%0d data=%02h c=%0d want 0/00/0", bus.rsp_valid, bus.rsp_data, bus.rsp_carry); else passes++;
    reset = 1'b0;
    act = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (bus.rf_enable || bus.rsp_valid) act++;
    end
    checks++; if (act !== 0) $display("FAIL mid_reset_quiet: activity cycles %0d want 0", act); else passes++;
    $display("reset during ADD CAP_B applied");
    issue(RDR, 2'd3, 2'd0, 8'h00, lat, data, carry, nrd, rsel0, rsel1, nwr, wsel, wdat, nrw0);
    checks++; if (data !== 8'h22) $display("FAIL mid_reset_target_kept: got %02h want 22", data); else passes++;
    @(posedge clk); #1;
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_op = 2'd0; bus.cmd_rd = 2'd0; bus.cmd_rs = 2'd0; bus.cmd_imm = 8'h00;
    test_reset();
    test_ldi();
    test_mov_rdr();
    test_add_carry();
    test_add_self();
    test_back_to_back();
    test_reset_mid_add();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
